// File: rtl/multi_channel_debouncer.sv
// Multi-channel push-button debouncer: per-channel synchronizer, debounce FSM, press/release pulses.
// Optional auto-repeat press pulses while held are enabled by defining DEBOUNCER_REPEAT_EN.
module multi_channel_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 65536,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 8000000,
    parameter int REPEAT_PERIOD = 2000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    // "release" is a reserved word, so the release pulse port is named released
    output logic [CHANNELS-1:0] released
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

`ifdef DEBOUNCER_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_reg;
        logic                   s;
        logic [1:0]             state_reg, state_next;
        logic [CNT_W-1:0]       cnt_reg, cnt_next;
        logic                   level_reg, level_next;
        logic                   press_reg, press_next;
        logic                   release_reg, release_next;
        logic                   press_d;
        logic                   cnt_done;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_reg <= '0;
            end else begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
            end
        end

        assign s        = sync_reg[SYNC_STAGES-1];
        assign cnt_done = (cnt_reg == CNT_LAST);

        // Any disagreement during a wait state restarts from the stable state with no output.
        always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            level_next   = level_reg;
            press_next   = 1'b0;
            release_next = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (s) begin
                        state_next = ST_PRESS_WAIT;
                        cnt_next   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else if (cnt_done) begin
                        state_next = ST_HELD;
                        cnt_next   = '0;
                        level_next = 1'b1;
                        press_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state_next = ST_RELEASE_WAIT;
                        cnt_next   = '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        state_next = ST_HELD;
                        cnt_next   = '0;
                    end else if (cnt_done) begin
                        state_next   = ST_IDLE;
                        cnt_next     = '0;
                        level_next   = 1'b0;
                        release_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    level_next = 1'b0;
                end
            endcase
        end

`ifdef DEBOUNCER_REPEAT_EN
        logic [RPT_W-1:0] rpt_reg, rpt_next;
        logic             rpt_first_reg, rpt_first_next;
        logic             rpt_fire;

        // Counts every cycle spent held (bounces included); a release edge wins over a repeat.
        always_comb begin
            rpt_next       = rpt_reg;
            rpt_first_next = rpt_first_reg;
            rpt_fire       = 1'b0;
            if (state_next == ST_IDLE || state_next == ST_PRESS_WAIT ||
                state_reg == ST_PRESS_WAIT) begin
                rpt_next       = '0;
                rpt_first_next = 1'b1;
            end else if (rpt_reg == (rpt_first_reg ? RPT_FIRST : RPT_NEXT)) begin
                rpt_fire       = 1'b1;
                rpt_next       = '0;
                rpt_first_next = 1'b0;
            end else begin
                rpt_next = rpt_reg + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rpt_reg       <= '0;
                rpt_first_reg <= 1'b1;
            end else begin
                rpt_reg       <= rpt_next;
                rpt_first_reg <= rpt_first_next;
            end
        end

        assign press_d = press_next | rpt_fire;
`else
        assign press_d = press_next;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg   <= ST_IDLE;
                cnt_reg     <= '0;
                level_reg   <= 1'b0;
                press_reg   <= 1'b0;
                release_reg <= 1'b0;
            end else begin
                state_reg   <= state_next;
                cnt_reg     <= cnt_next;
                level_reg   <= level_next;
                press_reg   <= press_d;
                release_reg <= release_next;
            end
        end

        assign level[gi]    = level_reg;
        assign press[gi]    = press_reg;
        assign released[gi] = release_reg;
    end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench for multi_channel_debouncer: run-length behavioural model checked every cycle,
// plus directed latency / bounce / simultaneity / reset / auto-repeat checks.
module tb_multi_channel_debouncer;
    localparam int CH = 4;
    localparam int S  = 4;
    localparam int SS = 2;
    localparam int RD = 10;
    localparam int RP = 5;
`ifdef DEBOUNCER_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [CH-1:0] in_v = '0;
    logic [CH-1:0] level, press, released;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;

    logic [CH-1:0] exp_level = '0;
    logic [CH-1:0] exp_press = '0;
    logic [CH-1:0] exp_rel   = '0;
    logic [CH-1:0] hist[$];
    int            run[CH];
    int            age[CH];

    always #5 clk = ~clk;

    multi_channel_debouncer #(
        .CHANNELS(CH), .STABLE_CYCLES(S), .SYNC_STAGES(SS),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_v),
        .level(level), .press(press), .released(released)
    );

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    // Model: the FSM sees the input SS edges late; a level flips once S+1 consecutive
    // seen samples disagree with it. Repeats fire at held ages RD, RD+RP, ...
    initial forever begin
        logic [CH-1:0] sv;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            hist.delete();
            exp_level = '0;
            exp_press = '0;
            exp_rel   = '0;
            for (int i = 0; i < CH; i++) begin
                run[i] = 0;
                age[i] = 0;
            end
        end else begin
            hist.push_back(in_v);
            sv = '0;
            if (hist.size() > SS) sv = hist.pop_front();
            exp_press = '0;
            exp_rel   = '0;
            for (int i = 0; i < CH; i++) begin
                if (sv[i] != exp_level[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == S + 1) begin
                    run[i] = 0;
                    exp_level[i] = ~exp_level[i];
                    if (exp_level[i]) exp_press[i] = 1'b1;
                    else exp_rel[i] = 1'b1;
                    age[i] = 0;
                end else if (exp_level[i]) begin
                    age[i]++;
                    if (REPEAT_EN && age[i] >= RD && ((age[i] - RD) % RP) == 0)
                        exp_press[i] = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        n_cmp++;
        if ({level, press, released} !== {exp_level, exp_press, exp_rel}) begin
            n_bad++;
            $display("FAIL cycle_check edge %0d: got level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                     edge_cnt, level, press, released, exp_level, exp_press, exp_rel);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int ch, input bit rel, input int max, output int e);
        e = -1;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if ((rel ? released[ch] : press[ch]) === 1'b1) begin
                e = edge_cnt;
                break;
            end
        end
        #1;
    endtask

    logic [CH-1:0] vec_val [8] = '{4'b0101, 4'b1111, 4'b0000, 4'b1010, 4'b1001, 4'b1011, 4'b0000, 4'b0000};
    int            vec_len [8] = '{6, 2, 7, 5, 1, 3, 8, 4};

    initial begin
        int n, e, seen, cnt, first;
        logic [19:0] bounce;
        #1 rst_n = 1'b0;
        tick(3);
        check("reset_level", int'(level), 0);
        check("reset_press", int'(press), 0);
        check("reset_release", int'(released), 0);
        rst_n = 1'b1;
        tick(3);

        // Single press: 6-edge latency each way
        in_v[0] = 1'b1;
        n = edge_cnt + 1;
        wait_pulse(0, 1'b0, 20, e);
        check("press0_latency", e, n + 6);
        check("level0_high", int'(level[0]), 1);
        tick(1);
        check("press0_one_cycle", int'(press[0]), 0);
        tick(4);
        in_v[0] = 1'b0;
        n = edge_cnt + 1;
        wait_pulse(0, 1'b1, 20, e);
        check("release0_latency", e, n + 6);
        check("level0_low", int'(level[0]), 0);
        tick(3);

        // Bounce: 3 high, 1 low, 3 high -> nothing
        bounce = 20'b00000000000001110111;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            in_v[1] = bounce[k];
            @(negedge clk);
            seen = seen | int'(level[1]) | int'(press[1]);
            #1;
        end
        check("bounce1_quiet", seen, 0);

        // Simultaneous events on channels 2 and 3
        in_v[3:2] = 2'b11;
        n = edge_cnt + 1;
        wait_pulse(2, 1'b0, 20, e);
        check("press23_latency", e, n + 6);
        check("press23_together", int'(press), 12);
        check("level23", int'(level), 12);
        in_v[3:2] = 2'b00;
        wait_pulse(3, 1'b1, 20, e);
        check("release23_together", int'(released), 12);
        tick(3);

        // Reset while channel 0 is mid-count, input held throughout
        in_v[0] = 1'b1;
        tick(5);
        rst_n = 1'b0;
        #1;
        check("midcount_reset_outputs", int'({level, press, released}), 0);
        tick(1);
        rst_n = 1'b1;
        n = edge_cnt + 1;
        wait_pulse(0, 1'b0, 20, e);
        check("press0_after_reset", e, n + 6);

        // Reset while held: level drops at once, fresh press after full latency
        tick(2);
        rst_n = 1'b0;
        #1;
        check("held_reset_level", int'(level), 0);
        tick(1);
        rst_n = 1'b1;
        n = edge_cnt + 1;
        wait_pulse(0, 1'b0, 20, e);
        check("press0_fresh_after_reset", e, n + 6);

        // Held for 30 edges after HELD entry: repeats only with the macro
        cnt = 0;
        first = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (press[0] === 1'b1) begin
                cnt++;
                if (first < 0) first = edge_cnt;
            end
        end
        #1;
        check("repeat_count", cnt, REPEAT_EN ? 5 : 0);
        check("repeat_first_edge", first, REPEAT_EN ? e + RD : -1);
        in_v[0] = 1'b0;
        tick(10);

        // Mixed multi-channel vectors, checked by the per-cycle model
        for (int v = 0; v < 8; v++) begin
            in_v = vec_val[v];
            tick(vec_len[v]);
        end
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
